// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Write-back arbiter feeding the single regfile write port. ALU and LSU
//   results are buffered in per-source FIFOs and drained at most one per
//   cycle through a registered output stage. A pending-write mask covers
//   every queued entry plus the write currently on o_rd, so issue logic can
//   stall read-after-write hazards.
//
// Parameters
//   DEPTH  entries per source FIFO (power of 2, >= 2)
//   AW     log2(DEPTH)
//
// Ports
//   clk                    clock, all logic on posedge
//   rst                    synchronous reset, active-low
//   i_alu_valid/o_alu_ready/i_alu_rd/i_alu_data   ALU result push interface
//   i_lsu_valid/o_lsu_ready/i_lsu_rd/i_lsu_data   LSU load result push interface
//   o_rd/o_rd_wen/o_rd_data                       regfile write port
//   o_pend_mask            bit r set while a write to xr is queued or on o_rd
//
// Round-robin pointer states:
//   state  | meaning
//   RR_ALU | ALU wins when both FIFOs hold entries
//   RR_LSU | LSU wins when both FIFOs hold entries

module wb_arbiter_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  logic [4:0]  push_rd,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        not_empty,
  output logic [4:0]  head_rd,
  output logic [63:0] head_data,
  output logic [31:0] mask
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]       mem_rd   [DEPTH];
  logic [63:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             store;
  logic             do_pop;

  // Ready comes from the registered count only: a full FIFO refuses a push
  // even in a cycle where it is also popping.
  assign ready     = (count != FULL_CNT);
  assign not_empty = (count != '0);

  // Writes to x0 complete the handshake but are dropped here.
  assign store     = push_valid & ready & (push_rd != 5'd0);
  assign do_pop    = pop & not_empty;

  assign head_rd   = mem_rd[rptr];
  assign head_data = mem_data[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (store) begin
        mem_rd[wptr]   <= push_rd;
        mem_data[wptr] <= push_data;
        ent_vld[wptr]  <= 1'b1;
        wptr           <= wptr + AW'(1);
      end
      // store and pop never address the same slot: that would need the
      // FIFO to be both empty (no pop) and full (no store).
      if (do_pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + AW'(1);
      end
      case ({store, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        mask[mem_rd[i]] = 1'b1;
      end
    end
    mask[0] = 1'b0;
  end

endmodule

module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd,
  input  logic [63:0] i_alu_data,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [63:0] i_lsu_data,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic [63:0] o_rd_data,
  output logic [31:0] o_pend_mask
);

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_state_t;

  rr_state_t rr_state;
  rr_state_t rr_next;

  logic        alu_ne;
  logic        lsu_ne;
  logic        alu_pop;
  logic        lsu_pop;
  logic [4:0]  alu_head_rd;
  logic [4:0]  lsu_head_rd;
  logic [63:0] alu_head_data;
  logic [63:0] lsu_head_data;
  logic [31:0] alu_mask;
  logic [31:0] lsu_mask;
  logic [31:0] out_mask;

  wb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (i_alu_valid),
    .push_rd    (i_alu_rd),
    .push_data  (i_alu_data),
    .pop        (alu_pop),
    .ready      (o_alu_ready),
    .not_empty  (alu_ne),
    .head_rd    (alu_head_rd),
    .head_data  (alu_head_data),
    .mask       (alu_mask)
  );

  wb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (i_lsu_valid),
    .push_rd    (i_lsu_rd),
    .push_data  (i_lsu_data),
    .pop        (lsu_pop),
    .ready      (o_lsu_ready),
    .not_empty  (lsu_ne),
    .head_rd    (lsu_head_rd),
    .head_data  (lsu_head_data),
    .mask       (lsu_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_state <= RR_ALU;
    end else begin
      rr_state <= rr_next;
    end
  end

  // The pointer only moves when there was a real contest; a lone source
  // never steals the other's next turn.
  always_comb begin
    alu_pop = 1'b0;
    lsu_pop = 1'b0;
    rr_next = rr_state;
    if (alu_ne && lsu_ne) begin
      if (rr_state == RR_ALU) begin
        alu_pop = 1'b1;
        rr_next = RR_LSU;
      end else begin
        lsu_pop = 1'b1;
        rr_next = RR_ALU;
      end
    end else if (alu_ne) begin
      alu_pop = 1'b1;
    end else if (lsu_ne) begin
      lsu_pop = 1'b1;
    end
  end

  // Output stage: o_rd/o_rd_data hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_rd      <= '0;
      o_rd_data <= '0;
      o_rd_wen  <= 1'b0;
    end else begin
      o_rd_wen <= alu_pop | lsu_pop;
      if (alu_pop) begin
        o_rd      <= alu_head_rd;
        o_rd_data <= alu_head_data;
      end else if (lsu_pop) begin
        o_rd      <= lsu_head_rd;
        o_rd_data <= lsu_head_data;
      end
    end
  end

  always_comb begin
    out_mask = '0;
    if (o_rd_wen) begin
      out_mask[o_rd] = 1'b1;
    end
  end

  assign o_pend_mask = (alu_mask | lsu_mask | out_mask) & ~32'd1;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [63:0] lsu_data = '0;
  logic        alu_ready;
  logic        lsu_ready;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_data;
  logic [31:0] o_pend_mask;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .i_lsu_valid (lsu_valid),
    .o_lsu_ready (lsu_ready),
    .i_lsu_rd    (lsu_rd),
    .i_lsu_data  (lsu_data),
    .o_rd        (o_rd),
    .o_rd_wen    (o_rd_wen),
    .o_rd_data   (o_rd_data),
    .o_pend_mask (o_pend_mask)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ldat;
    logic        ewen;
    logic [4:0]  erd;
    logic [63:0] edat;
    logic [31:0] emask;
  } vec_t;

  ent_t qa[$];
  ent_t ql[$];
  ent_t sb[$];

  logic        m_rr = 1'b0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;
  logic        last_alu_acc = 1'b0;
  logic        last_lsu_acc = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_nz   = 0;
  int wr_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (qa[i]) m[qa[i].rd] = 1'b1;
    foreach (ql[i]) m[ql[i].rd] = 1'b1;
    if (m_wen) m[m_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Reference model, advanced at each rising edge from the inputs held then.
  task automatic model_update();
    logic a_rdy, l_rdy, a_ne, l_ne;
    ent_t e;
    if (!rst) begin
      qa.delete();
      ql.delete();
      sb.delete();
      m_rr = 1'b0;
      m_wen = 1'b0;
      m_rd = '0;
      m_data = '0;
      last_alu_acc = 1'b0;
      last_lsu_acc = 1'b0;
      return;
    end
    a_rdy = (qa.size() != DEPTH);
    l_rdy = (ql.size() != DEPTH);
    a_ne  = (qa.size() > 0);
    l_ne  = (ql.size() > 0);
    m_wen = 1'b0;
    e = '{rd: '0, data: '0};
    if (a_ne && (!l_ne || !m_rr)) begin
      e = qa.pop_front();
      m_wen = 1'b1;
    end else if (l_ne) begin
      e = ql.pop_front();
      m_wen = 1'b1;
    end
    if (a_ne && l_ne) m_rr = !m_rr;
    if (m_wen) begin
      m_rd = e.rd;
      m_data = e.data;
      sb.push_back(e);
    end
    last_alu_acc = alu_valid && a_rdy;
    last_lsu_acc = lsu_valid && l_rdy;
    if (last_alu_acc && alu_rd != 5'd0) begin
      qa.push_back('{rd: alu_rd, data: alu_data});
      acc_nz++;
    end
    if (last_lsu_acc && lsu_rd != 5'd0) begin
      ql.push_back('{rd: lsu_rd, data: lsu_data});
      acc_nz++;
    end
  endtask

  task automatic compare();
    ent_t e;
    check("alu_ready", 64'(alu_ready), 64'(qa.size() != DEPTH));
    check("lsu_ready", 64'(lsu_ready), 64'(ql.size() != DEPTH));
    check("rd_wen", 64'(o_rd_wen), 64'(m_wen));
    check("rd_hold", 64'(o_rd), 64'(m_rd));
    check("rd_data_hold", o_rd_data, m_data);
    check("pend_mask", 64'(o_pend_mask), 64'(model_mask()));
    if (o_rd_wen) begin
      wr_seen++;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_rd", 64'(o_rd), 64'(e.rd));
        check("sb_data", o_rd_data, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    alu_rd = '0;
    lsu_rd = '0;
    alu_data = '0;
    lsu_data = '0;
  endtask

  function automatic logic [4:0] pick_rd(input logic [4:0] excl);
    logic [31:0] m;
    logic [4:0]  r;
    m = model_mask();
    for (int t = 0; t < 8; t++) begin
      r = 5'($urandom_range(0, 31));
      if (r == 5'd0) return r;
      if (!m[r] && r != excl) return r;
    end
    return 5'd0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    logic [4:0] wr_list[$];
    int ai, li, ready_low, k;
    logic [4:0] exp_rd;

    vecs[0]  = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,    32'h20};
    vecs[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h1234, 32'h20};
    vecs[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 64'h1234, 32'h0};
    vecs[3]  = '{1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 64'h1234, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 64'h1234, 32'h0};
    vecs[5]  = '{1'b1, 5'd3, 64'hA,    1'b1, 5'd7, 64'hB, 1'b0, 5'd5, 64'h1234, 32'h88};
    vecs[6]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'hA,    32'h88};
    vecs[7]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hB,    32'h80};
    vecs[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 64'hB,    32'h0};
    vecs[9]  = '{1'b1, 5'd4, 64'hC,    1'b1, 5'd6, 64'hD, 1'b0, 5'd7, 64'hB,    32'h50};
    vecs[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'hD,    32'h50};
    vecs[11] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 64'hC,    32'h10};
    vecs[12] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0, 1'b0, 5'd4, 64'hC,    32'h0};

    // Reset state
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    check("rst_wen", 64'(o_rd_wen), 64'd0);
    check("rst_rd", 64'(o_rd), 64'd0);
    check("rst_data", o_rd_data, 64'd0);
    check("rst_mask", 64'(o_pend_mask), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    rst = 1'b1;
    step();

    // Directed vectors: latency, hold, rd=0 drop, round-robin pointer behaviour
    for (int i = 0; i < 13; i++) begin
      alu_valid = vecs[i].av;
      alu_rd    = vecs[i].ard;
      alu_data  = vecs[i].adat;
      lsu_valid = vecs[i].lv;
      lsu_rd    = vecs[i].lrd;
      lsu_data  = vecs[i].ldat;
      step();
      check($sformatf("vec%0d_wen", i), 64'(o_rd_wen), 64'(vecs[i].ewen));
      check($sformatf("vec%0d_rd", i), 64'(o_rd), 64'(vecs[i].erd));
      check($sformatf("vec%0d_data", i), o_rd_data, vecs[i].edat);
      check($sformatf("vec%0d_mask", i), 64'(o_pend_mask), 64'(vecs[i].emask));
      check($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'd1);
    end
    idle_inputs();

    // Both sources valid every cycle: strict alternation, backpressure at full
    ai = 0;
    li = 0;
    ready_low = 0;
    for (int c = 0; c < 30; c++) begin
      alu_valid = (ai < 8);
      alu_rd    = 5'(1 + ai);
      alu_data  = 64'hA000 + 64'(ai);
      lsu_valid = (li < 8);
      lsu_rd    = 5'(9 + li);
      lsu_data  = 64'hB000 + 64'(li);
      step();
      if (last_alu_acc) ai++;
      if (last_lsu_acc) li++;
      if (!alu_ready) ready_low++;
      if (o_rd_wen) wr_list.push_back(o_rd);
    end
    idle_inputs();
    check("alt_pulses", 64'(wr_list.size()), 64'd16);
    check("alt_alu_ready_low_seen", 64'(ready_low > 0), 64'd1);
    k = 0;
    foreach (wr_list[j]) begin
      exp_rd = (j % 2 == 0) ? 5'(1 + j / 2) : 5'(9 + j / 2);
      check($sformatf("alt_order%0d", j), 64'(wr_list[j]), 64'(exp_rd));
      k++;
    end

    // Fill as far as the single write port allows, then reset mid-flight
    ai = 0;
    li = 0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (ai < 7);
      alu_rd    = 5'(17 + ai);
      alu_data  = 64'hC000 + 64'(ai);
      lsu_valid = (li < 7);
      lsu_rd    = 5'(24 + li);
      lsu_data  = 64'hD000 + 64'(li);
      step();
      if (last_alu_acc) ai++;
      if (last_lsu_acc) li++;
      if (qa.size() + ql.size() == 7) break;
    end
    check("fill_one_side_full", 64'(alu_ready & lsu_ready), 64'd0);
    check("fill_mask_nonzero", 64'(o_pend_mask != 32'd0), 64'd1);
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_wen", 64'(o_rd_wen), 64'd0);
    check("midrst_rd", 64'(o_rd), 64'd0);
    check("midrst_data", o_rd_data, 64'd0);
    check("midrst_mask", 64'(o_pend_mask), 64'd0);
    check("midrst_alu_ready", 64'(alu_ready), 64'd1);
    check("midrst_lsu_ready", 64'(lsu_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      check("postrst_no_write", 64'(o_rd_wen), 64'd0);
    end

    // Random traffic against the model; issue side never reuses a pending rd
    acc_nz  = 0;
    wr_seen = 0;
    for (int c = 0; c < 10000; c++) begin
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = pick_rd(5'd0);
      alu_data  = {$urandom, $urandom};
      lsu_valid = ($urandom_range(0, 9) < 6);
      lsu_rd    = pick_rd(alu_valid ? alu_rd : 5'd0);
      lsu_data  = {$urandom, $urandom};
      if (alu_valid && lsu_valid && alu_rd == lsu_rd) lsu_rd = 5'd0;
      step();
    end
    idle_inputs();
    for (int c = 0; c < 20; c++) step();
    check("rand_all_written", 64'(wr_seen), 64'(acc_nz));
    check("rand_sb_drained", 64'(sb.size()), 64'd0);
    check("rand_mask_idle", 64'(o_pend_mask), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
